// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared constants, state encoding and rate helper for the Keccak absorb front end
package keccak_pkg;

    localparam int RATE_BYTES_128 = 168;
    localparam int RATE_BYTES_256 = 136;

    localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
    localparam logic [7:0] PAD_LAST     = 8'h80;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABSORB = 3'd1,
        FULL   = 3'd2,
        LAST   = 3'd3
    } state_t;

    // mode 1 selects SHAKE128, mode 0 selects SHAKE256
    function automatic int rate_bytes(input logic mode);
        return mode ? RATE_BYTES_128 : RATE_BYTES_256;
    endfunction

endpackage

// File: rtl/serial_byte_packer.sv
// rtl/serial_byte_packer.sv - assembles MSB-first IN_W-bit chunks into bytes
module serial_byte_packer #(
    parameter int IN_W = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_clear,
    input  logic            i_chunk_valid,
    input  logic [IN_W-1:0] i_chunk_data,
    output logic            o_byte_valid,
    output logic [7:0]      o_byte_out,
    output logic            o_partial
);

    localparam int CHUNKS = 8 / IN_W;

    logic [7:0] r_shift;
    logic [3:0] r_count;
    logic       w_last_chunk;

    assign w_last_chunk = (r_count == 4'(CHUNKS - 1));
    assign o_byte_valid = i_chunk_valid && w_last_chunk;
    assign o_byte_out   = 8'({r_shift, i_chunk_data});
    // partial reflects the state after this cycle's chunk, so a coincident end sees it
    assign o_partial    = i_chunk_valid ? !w_last_chunk : (r_count != 4'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= 8'd0;
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_shift <= 8'd0;
            r_count <= 4'd0;
        end else if (i_chunk_valid) begin
            r_shift <= o_byte_out;
            r_count <= w_last_chunk ? 4'd0 : r_count + 4'd1;
        end
    end

endmodule

// File: rtl/keccak_absorb_padder.sv
// rtl/keccak_absorb_padder.sv - serial absorb front end with SHAKE domain separation and pad10*1
module keccak_absorb_padder
    import keccak_pkg::*;
#(
    parameter int IN_W     = 2,
    parameter int RATE_MAX = 1344,
    parameter int CNT_W    = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic                i_in_valid,
    input  logic [IN_W-1:0]     i_in_data,
    output logic                o_in_ready,
    input  logic                i_in_end,
    output logic [RATE_MAX-1:0] o_blk_data,
    output logic                o_blk_valid,
    output logic                o_blk_last,
    input  logic                i_blk_ready,
    output logic                o_busy,
    output logic                o_frag_err,
    output logic [2:0]          o_dbg_state,
    output logic [CNT_W-1:0]    o_dbg_bytecount
);

    localparam int IDX_W = $clog2(RATE_MAX);

    state_t              r_state;
    logic                r_mode;
    logic [RATE_MAX-1:0] r_buf;
    logic [CNT_W-1:0]    r_bytecount;
    logic                r_end_pending;
    logic                r_frag_err;
    logic                r_in_ready;
    logic                r_blk_valid;
    logic                r_blk_last;

    logic                w_chunk_valid;
    logic                w_pk_clear;
    logic                w_byte_valid;
    logic [7:0]          w_byte_out;
    logic                w_partial;
    logic [CNT_W-1:0]    w_rate;
    logic [CNT_W-1:0]    w_count_wr;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_end_idx;
    logic [IDX_W-1:0]    w_last_idx;
    logic [RATE_MAX-1:0] w_buf_wr;
    logic [RATE_MAX-1:0] w_pad_buf;
    logic [RATE_MAX-1:0] w_pad_only;

    assign w_rate        = CNT_W'(rate_bytes(r_mode));
    assign w_chunk_valid = i_in_valid && r_in_ready;
    // a message end flushes any half-assembled byte so it cannot leak into the next message
    assign w_pk_clear    = ((r_state == IDLE) && i_start) || ((r_state == ABSORB) && i_in_end);

    serial_byte_packer #(
        .IN_W(IN_W)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_pk_clear),
        .i_chunk_valid(w_chunk_valid),
        .i_chunk_data (i_in_data),
        .o_byte_valid (w_byte_valid),
        .o_byte_out   (w_byte_out),
        .o_partial    (w_partial)
    );

    assign w_wr_idx   = IDX_W'({r_bytecount, 3'b000});
    assign w_end_idx  = IDX_W'({w_count_wr, 3'b000});
    assign w_last_idx = IDX_W'({w_rate - CNT_W'(1), 3'b000});

    always_comb begin
        w_buf_wr   = r_buf;
        w_count_wr = r_bytecount;
        if (w_byte_valid) begin
            w_buf_wr[w_wr_idx +: 8] = w_byte_out;
            w_count_wr              = r_bytecount + CNT_W'(1);
        end
        w_pad_buf                   = w_buf_wr;
        w_pad_buf[w_end_idx +: 8]   = w_pad_buf[w_end_idx +: 8] ^ SHAKE_SUFFIX;
        w_pad_buf[w_last_idx +: 8]  = w_pad_buf[w_last_idx +: 8] ^ PAD_LAST;
        w_pad_only                  = '0;
        w_pad_only[7:0]             = SHAKE_SUFFIX;
        w_pad_only[w_last_idx +: 8] = PAD_LAST;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_mode        <= 1'b0;
            r_buf         <= '0;
            r_bytecount   <= '0;
            r_end_pending <= 1'b0;
            r_frag_err    <= 1'b0;
            r_in_ready    <= 1'b0;
            r_blk_valid   <= 1'b0;
            r_blk_last    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mode        <= i_mode;
                        r_buf         <= '0;
                        r_bytecount   <= '0;
                        r_end_pending <= 1'b0;
                        r_frag_err    <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_state       <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (w_count_wr == w_rate) begin
                        // block full takes priority; a coincident end is deferred to a pad-only block
                        r_buf         <= w_buf_wr;
                        r_bytecount   <= w_count_wr;
                        r_end_pending <= i_in_end;
                        r_in_ready    <= 1'b0;
                        r_blk_valid   <= 1'b1;
                        r_blk_last    <= 1'b0;
                        r_state       <= FULL;
                    end else if (i_in_end) begin
                        r_buf         <= w_pad_buf;
                        r_bytecount   <= w_count_wr;
                        r_frag_err    <= r_frag_err | w_partial;
                        r_in_ready    <= 1'b0;
                        r_blk_valid   <= 1'b1;
                        r_blk_last    <= 1'b1;
                        r_state       <= LAST;
                    end else begin
                        r_buf         <= w_buf_wr;
                        r_bytecount   <= w_count_wr;
                    end
                end
                FULL: begin
                    if (i_in_end) begin
                        r_end_pending <= 1'b1;
                    end
                    if (i_blk_ready) begin
                        r_bytecount <= '0;
                        if (r_end_pending || i_in_end) begin
                            r_buf         <= w_pad_only;
                            r_blk_last    <= 1'b1;
                            r_end_pending <= 1'b0;
                            r_state       <= LAST;
                        end else begin
                            r_buf       <= '0;
                            r_blk_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= ABSORB;
                        end
                    end
                end
                LAST: begin
                    if (i_blk_ready) begin
                        r_buf       <= '0;
                        r_bytecount <= '0;
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready      = r_in_ready;
    assign o_blk_data      = r_buf;
    assign o_blk_valid     = r_blk_valid;
    assign o_blk_last      = r_blk_last;
    assign o_busy          = (r_state != IDLE);
    assign o_frag_err      = r_frag_err;
    assign o_dbg_state     = r_state;
    assign o_dbg_bytecount = r_bytecount;

endmodule

// File: tb/tb_keccak_absorb_padder.sv
// tb/tb_keccak_absorb_padder.sv - scoreboard bench for keccak_absorb_padder
module tb_keccak_absorb_padder;

    localparam int IN_W     = 2;
    localparam int RATE_MAX = 1344;
    localparam int CNT_W    = 8;
    localparam int CPB      = 8 / IN_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                mode;
    logic                in_valid;
    logic [IN_W-1:0]     in_data;
    logic                in_ready;
    logic                in_end;
    logic [RATE_MAX-1:0] blk_data;
    logic                blk_valid;
    logic                blk_last;
    logic                blk_ready;
    logic                busy;
    logic                frag_err;
    logic [2:0]          dbg_state;
    logic [CNT_W-1:0]    dbg_bytecount;

    always #5 clk = ~clk;

    keccak_absorb_padder #(
        .IN_W    (IN_W),
        .RATE_MAX(RATE_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_mode         (mode),
        .i_in_valid     (in_valid),
        .i_in_data      (in_data),
        .o_in_ready     (in_ready),
        .i_in_end       (in_end),
        .o_blk_data     (blk_data),
        .o_blk_valid    (blk_valid),
        .o_blk_last     (blk_last),
        .i_blk_ready    (blk_ready),
        .o_busy         (busy),
        .o_frag_err     (frag_err),
        .o_dbg_state    (dbg_state),
        .o_dbg_bytecount(dbg_bytecount)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [RATE_MAX-1:0] exp_data_q[$];
    bit                  exp_last_q[$];
    byte unsigned        g_msg[$];
    int                  lowcnt = 0;
    bit                  prev_stall = 0;
    logic [RATE_MAX-1:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input logic [RATE_MAX-1:0] act, input logic [RATE_MAX-1:0] exp,
                           input logic act_last, input bit exp_last);
        int k;
        n_cmp++;
        if (act !== exp || act_last !== exp_last) begin
            n_err++;
            k = 0;
            for (int i = RATE_MAX / 8 - 1; i >= 0; i--)
                if (act[8*i +: 8] !== exp[8*i +: 8]) k = i;
            $display("FAIL block: byte %0d got %02h expected %02h, last got %0d expected %0d",
                     k, act[8*k +: 8], exp[8*k +: 8], act_last, exp_last);
        end
    endtask

    // Reference: message ++ 0x1F, zero-fill to a rate multiple, last byte ^= 0x80
    task automatic build_expected(input int rate);
        byte unsigned        p[$];
        logic [RATE_MAX-1:0] blk;
        int                  nb;
        p = g_msg;
        p.push_back(8'h1F);
        while (p.size() % rate != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        nb = p.size() / rate;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int k = 0; k < rate; k++) blk[8*k +: 8] = p[b*rate + k];
            exp_data_q.push_back(blk);
            exp_last_q.push_back(b == nb - 1);
        end
    endtask

    // Consumer backpressure with random low bursts of up to 6 cycles
    initial begin
        blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (lowcnt > 0) begin
                blk_ready = 1'b0;
                lowcnt--;
            end else begin
                blk_ready = 1'b1;
                if ($urandom % 4 == 0) lowcnt = $urandom_range(1, 6);
            end
        end
    end

    always @(negedge clk) begin
        logic [RATE_MAX-1:0] ed;
        bit                  el;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", blk_valid, 1);
                chk("hold_data_stable", blk_data === prev_data, 1);
            end
            if (blk_valid) chk("in_ready_low_while_blk", in_ready, 0);
            if (blk_valid && blk_ready) begin
                if (exp_data_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_block: got a block, expected none");
                end else begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    chk_blk(blk_data, ed, blk_last, el);
                end
            end
            prev_stall = blk_valid && !blk_ready;
            prev_data  = blk_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 1'($urandom);
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        chk("frag_clear_after_start", frag_err, 0);
    endtask

    task automatic send_chunk(input logic [IN_W-1:0] d, input bit with_end);
        bit ok = 0;
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        if ($urandom % 16 == 0) begin
            start = 1'b1;
            mode  = 1'($urandom);
        end
        while (!ok && guard < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok     = 1;
                in_end = with_end;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_end   = 1'b0;
        start    = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL chunk_timeout: in_ready 0 for %0d cycles, expected 1", guard);
        end
        if ($urandom % 4 == 0) tick();
    endtask

    task automatic send_bytes(input bit end_on_last);
        logic [7:0] bv;
        for (int i = 0; i < g_msg.size(); i++) begin
            bv = g_msg[i];
            for (int c = 0; c < CPB; c++)
                send_chunk(bv[(CPB-1-c)*IN_W +: IN_W], end_on_last && i == g_msg.size()-1 && c == CPB-1);
        end
    endtask

    task automatic send_msg(input bit m, input bit coincident, input int partial);
        int  guard = 0;
        bit  end_with_chunk;
        end_with_chunk = coincident && partial == 0 && g_msg.size() > 0;
        build_expected(m ? 168 : 136);
        do_start(m);
        send_bytes(end_with_chunk);
        for (int p = 0; p < partial; p++) send_chunk(IN_W'($urandom), 1'b0);
        if (!end_with_chunk) begin
            in_end = 1'b1;
            tick();
            in_end = 1'b0;
        end
        while (busy && guard < 5000) begin
            tick();
            guard++;
        end
        chk("message_done", busy, 0);
        chk("frag_err", frag_err, partial > 0);
        chk("blocks_drained", exp_data_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_blk_valid"}, blk_valid, 0);
        chk({tag, "_blk_last"}, blk_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frag_err"}, frag_err, 0);
        chk({tag, "_bytecount"}, dbg_bytecount, 0);
        chk({tag, "_blk_data_zero"}, blk_data == '0, 1);
    endtask

    task automatic fill_random(input int n);
        g_msg = {};
        for (int i = 0; i < n; i++) g_msg.push_back(8'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_end   = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        g_msg = {};
        send_msg(1'b0, 1'b0, 0);

        g_msg = {8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 1'b1, 0);

        g_msg = {};
        for (int i = 0; i < 135; i++) g_msg.push_back(8'hA5);
        send_msg(1'b0, 1'b0, 0);

        fill_random(136);
        send_msg(1'b0, 1'b0, 0);
        fill_random(136);
        send_msg(1'b0, 1'b1, 0);

        fill_random(200);
        send_msg(1'b1, 1'b1, 0);

        g_msg = {};
        send_msg(1'b0, 1'b0, 3);

        fill_random(10);
        do_start(1'b1);
        send_bytes(1'b0);
        tick();
        chk("bytecount_mid_absorb", dbg_bytecount, 10);
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("abort");
        rst = 1'b0;
        tick();
        g_msg = {8'h61, 8'h62, 8'h63};
        send_msg(1'b1, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            fill_random($urandom_range(0, 400));
            send_msg(1'($urandom), 1'($urandom), (t % 3 == 2) ? $urandom_range(1, CPB-1) : 0);
        end

        chk("queue_empty_at_end", exp_data_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_padder.md
# keccak_absorb_padder

Parametrised serial-input absorb front end for the Keccak/SHAKE cores. Assembles IN_W-bit serial chunks into bytes and rate-sized blocks, and applies SHAKE domain separation plus pad10*1 padding. Supports multi-block messages and runtime SHAKE128/SHAKE256 rate selection. Sits between the serial input pins and the permutation controller, and hands it blocks over a valid/ready handshake.

## Interface
- IN_W, 2: serial chunk width in bits; legal values 1, 2, 4, 8.
- RATE_MAX, 1344: block bus width in bits, equal to the SHAKE128 rate.
- CNT_W, 8: byte-counter width; must satisfy 2^CNT_W > RATE_MAX/8.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a new message; honoured only in IDLE.
- mode  in  1  rate select, sampled at start: 0 = SHAKE256 (136 bytes), 1 = SHAKE128 (168 bytes).
- in_valid  in  1  serial chunk present.
- in_data  in  IN_W  chunk; the first chunk of each byte carries the byte's MSBs.
- in_ready  out  1  chunk accepted when in_valid && in_ready.
- in_end  in  1  one-cycle end-of-message pulse.
- blk_data  out  RATE_MAX  block; byte k occupies bits [8k+7:8k]; bits at and above the rate are 0.
- blk_valid  out  1  block presented.
- blk_last  out  1  qualifies blk_valid; marks the final (padded) block.
- blk_ready  in  1  consumer accepts the block when blk_valid && blk_ready.
- busy  out  1  high in any state except IDLE.
- frag_err  out  1  sticky flag: in_end arrived with a partial byte. Cleared by start or reset.
- dbg_state  out  3  FSM state encoding.
- dbg_bytecount  out  CNT_W  bytes in the current block.

## Operation
- FSM states: IDLE, ABSORB, FULL, LAST.
- IDLE: on start, latch mode, clear the buffer, bytecount and bit position, then go to ABSORB.
- ABSORB: in_ready = 1. Each accepted chunk shifts into the byte assembler. When a byte completes, it is written to byte[bytecount] and bytecount increments.
- Block fills (bytecount reaches RATE_BYTES): go to FULL and present the block with blk_last = 0.
- in_end in ABSORB: byte[bytecount] ^= 0x1F and byte[RATE_BYTES-1] ^= 0x80 (giving 0x9F when they coincide), then go to LAST. A partial byte is discarded and frag_err is set.
- in_valid and in_end in the same cycle: the chunk is absorbed first, then end processing is applied.
- If that chunk fills the block, set end_pending and go to FULL.
- FULL: in_ready = 0. On handshake, clear the buffer and bytecount.
  - end_pending = 1: load the pure pad block (byte0 = 0x1F, last byte = 0x80) and go to LAST.
  - end_pending = 0: go to ABSORB.
- in_end arriving while in FULL sets end_pending.
- LAST: blk_valid = 1, blk_last = 1, in_ready = 0. On handshake go to IDLE.
- A message whose length is an exact multiple of the rate always produces an extra pad-only block.
- start outside IDLE is ignored; mode is ignored outside the start cycle.
- blk_data is held stable while blk_valid = 1 and blk_ready = 0.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready, blk_valid, blk_last, busy, frag_err = 0.
  - blk_data = 0, bytecount = 0, end_pending = 0.
- Reset asserted mid-message aborts immediately. No block is emitted afterwards.
- start at edge N: busy and in_ready are high after edge N.
- A chunk completing the rate at edge N gives blk_valid = 1 after edge N, with zero bubble. in_ready is low from the same cycle.
- in_end at edge N gives blk_valid = 1 and blk_last = 1 after edge N.
- Handshake at edge N:
  - blk_valid drops after N, or is replaced by the pad block in the same cycle when end_pending is set.
  - in_ready is high after N if the next state is ABSORB.
- Throughput: one chunk per cycle while in ABSORB.

## Structure
- Package keccak_pkg holds:
  - RATE_BYTES_128 = 168 and RATE_BYTES_256 = 136.
  - SHAKE_SUFFIX = 8'h1F and PAD_LAST = 8'h80.
  - The state enum {IDLE, ABSORB, FULL, LAST}.
- Sub-module serial_byte_packer (IN_W): chunk shifter that outputs byte_valid, byte_out and a partial flag, with a sync clear.
- The top level owns the FSM, byte write-enable decode, padding XOR and end_pending.

## Test plan
- Empty message, SHAKE256, IN_W = 2: start then in_end → one block with byte0 = 0x1F, byte135 = 0x80, all else 0, blk_last = 1.
- "abc" sent as 2-bit chunks MSB-first (0x61 → 01, 10, 00, 01) → bytes 61 62 63 1F, byte135 = 0x80.
- 135 bytes of 0xA5, SHAKE256 → single block with byte135 = 0x9F.
- 136 bytes, SHAKE256 → first block blk_last = 0 (raw data), second block 1F…80 with blk_last = 1. Repeat with in_end coincident with the final chunk: same two blocks.
- SHAKE128, IN_W = 8, 200 bytes → block 0 holds bytes 0–167 (blk_last = 0); block 1 holds 32 bytes then 0x1F, with byte167 = 0x80; bits at and above 1344 are always 0.
- Backpressure and abort:
  - blk_ready low for 5 cycles in FULL: in_ready = 0 and blk_data stable throughout; no chunk is lost.
  - Reset mid-ABSORB: all outputs return to their reset values, and the next message hashes correctly.
  - in_end after 3 chunks (IN_W = 2): frag_err = 1 and the partial bits are dropped.
